decode_stage: RTL and testbench

Parametrised MIPS instruction-decode pipeline stage: an integrated 2-read/1-write register file with write-through bypass, opcode-driven control decode, immediate extension, load-use hazard detection, and a valid/stall/flush pipeline register toward execute. It sits between the fetch stage and the execute stage. It replaces the fixed 32×32 decode block and adds four things: reset, handshaking, hazard stalls, and correct operand hold under back-pressure.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/reg_file.sv | 63 ++++++
 rtl/decode_stage.sv | 185 ++++++++++++++++++
 tb/tb_decode_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared decode definitions: opcodes, control bundle and the opcode decoder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic alu_src_imm;
        logic illegal;
    } ctrl_t;

    // Opcode to control bits; unknown opcodes raise only the illegal flag.
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: c.reg_write = 1'b1;
            OP_LW: begin
                c.reg_write   = 1'b1;
                c.mem_read    = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            OP_SW: begin
                c.mem_write   = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            OP_BEQ: c.branch = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI: begin
                c.reg_write   = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // Rt is only a true source operand for R-type, store and branch.
    function automatic logic rt_used(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file, 2 async read ports, 1 write port, r0 hardwired to 0.
// Latency: reads combinational with write-through of same-cycle write; writes land at posedge.
// Backpressure: none; writes always accepted.
module reg_file #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    localparam int REG_AW   = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [REG_AW-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data
);

    logic [DATA_W-1:0] rf_q [REG_COUNT];
    logic [DATA_W-1:0] rf_d [REG_COUNT];
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    // Next register contents: apply the write unless it targets r0.
    always_comb begin
        rf_d = rf_q;
        if (wr_live) begin
            rf_d[wr_addr] = wr_data;
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    // Read port 0: r0 is zero, same-cycle write is forwarded.
    always_comb begin
        rd0_data = rf_q[rd0_addr];
        if (rd0_addr == '0) begin
            rd0_data = '0;
        end else if (wr_live && (wr_addr == rd0_addr)) begin
            rd0_data = wr_data;
        end
    end

    // Read port 1: same rules as port 0.
    always_comb begin
        rd1_data = rf_q[rd1_addr];
        if (rd1_addr == '0) begin
            rd1_data = '0;
        end else if (wr_live && (wr_addr == rd1_addr)) begin
            rd1_data = wr_data;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: register read, control decode, immediate extension, load-use stall.
// Latency: 1 cycle from accept to ex_* outputs.
// Backpressure: ex_stall holds ex_* and drops id_ready; load-use hazard inserts one bubble.
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int IMM_W     = 16,
    localparam int REG_AW   = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_stall,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs_addr,
    output logic [REG_AW-1:0] ex_rt_addr,
    output logic [REG_AW-1:0] ex_dest,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_alu_src_imm,
    output logic              ex_illegal
);

    logic [5:0]        op;
    logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr, dest;
    logic [DATA_W-1:0] rs_data, rt_data, imm;
    logic [IMM_W-1:0]  imm_raw;
    ctrl_t             dec_ctrl;
    logic              hazard;
    logic              wb_live;

    logic              ex_valid_d,   ex_valid_q;
    logic [DATA_W-1:0] ex_rs_data_d, ex_rs_data_q;
    logic [DATA_W-1:0] ex_rt_data_d, ex_rt_data_q;
    logic [DATA_W-1:0] ex_imm_d,     ex_imm_q;
    logic [REG_AW-1:0] ex_rs_addr_d, ex_rs_addr_q;
    logic [REG_AW-1:0] ex_rt_addr_d, ex_rt_addr_q;
    logic [REG_AW-1:0] ex_dest_d,    ex_dest_q;
    logic [5:0]        ex_opcode_d,  ex_opcode_q;
    logic [5:0]        ex_funct_d,   ex_funct_q;
    ctrl_t             ex_ctrl_d,    ex_ctrl_q;

    assign op       = if_instr[31:26];
    assign rs_addr  = REG_AW'(if_instr[25:21]);
    assign rt_addr  = REG_AW'(if_instr[20:16]);
    assign rd_addr  = REG_AW'(if_instr[15:11]);
    assign imm_raw  = if_instr[IMM_W-1:0];
    assign dec_ctrl = decode(op);
    assign wb_live  = wb_en && (wb_addr != '0);

    reg_file #(
        .DATA_W   (DATA_W),
        .REG_COUNT(REG_COUNT)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wb_en),
        .wr_addr (wb_addr),
        .wr_data (wb_data),
        .rd0_addr(rs_addr),
        .rd0_data(rs_data),
        .rd1_addr(rt_addr),
        .rd1_data(rt_data)
    );

    // Destination select and immediate extension for the presented instruction.
    always_comb begin
        dest = '0;
        if (op == OP_RTYPE) begin
            dest = rd_addr;
        end else if ((op == OP_LW) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI)) begin
            dest = rt_addr;
        end
        if (zero_ext(op)) begin
            imm = {{(DATA_W-IMM_W){1'b0}}, imm_raw};
        end else begin
            imm = {{(DATA_W-IMM_W){imm_raw[IMM_W-1]}}, imm_raw};
        end
    end

    // Load in execute whose result the presented instruction needs this cycle.
    always_comb begin
        hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_dest_q != '0) &&
                 ((ex_dest_q == rs_addr) || ((ex_dest_q == rt_addr) && rt_used(op)));
        id_ready = flush || (!ex_stall && !hazard);
    end

    // Pipeline register next state: flush > stall (with operand refresh) > bubble > accept.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_imm_d     = ex_imm_q;
        ex_rs_addr_d = ex_rs_addr_q;
        ex_rt_addr_d = ex_rt_addr_q;
        ex_dest_d    = ex_dest_q;
        ex_opcode_d  = ex_opcode_q;
        ex_funct_d   = ex_funct_q;
        ex_ctrl_d    = ex_ctrl_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else if (ex_stall) begin
            if (wb_live && (wb_addr == ex_rs_addr_q)) begin
                ex_rs_data_d = wb_data;
            end
            if (wb_live && (wb_addr == ex_rt_addr_q)) begin
                ex_rt_data_d = wb_data;
            end
        end else if (hazard || !if_valid) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else begin
            ex_valid_d   = 1'b1;
            ex_rs_data_d = rs_data;
            ex_rt_data_d = rt_data;
            ex_imm_d     = imm;
            ex_rs_addr_d = rs_addr;
            ex_rt_addr_d = rt_addr;
            ex_dest_d    = dest;
            ex_opcode_d  = op;
            ex_funct_d   = if_instr[5:0];
            ex_ctrl_d    = dec_ctrl;
        end
    end

    // Pipeline register toward execute, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_addr_q <= '0;
            ex_rt_addr_q <= '0;
            ex_dest_q    <= '0;
            ex_opcode_q  <= '0;
            ex_funct_q   <= '0;
            ex_ctrl_q    <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs_addr_q <= ex_rs_addr_d;
            ex_rt_addr_q <= ex_rt_addr_d;
            ex_dest_q    <= ex_dest_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_funct_q   <= ex_funct_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    assign ex_valid       = ex_valid_q;
    assign ex_rs_data     = ex_rs_data_q;
    assign ex_rt_data     = ex_rt_data_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rs_addr     = ex_rs_addr_q;
    assign ex_rt_addr     = ex_rt_addr_q;
    assign ex_dest        = ex_dest_q;
    assign ex_opcode      = ex_opcode_q;
    assign ex_funct       = ex_funct_q;
    assign ex_reg_write   = ex_ctrl_q.reg_write;
    assign ex_mem_read    = ex_ctrl_q.mem_read;
    assign ex_mem_write   = ex_ctrl_q.mem_write;
    assign ex_branch      = ex_ctrl_q.branch;
    assign ex_alu_src_imm = ex_ctrl_q.alu_src_imm;
    assign ex_illegal     = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, async-reset sequence, randomized traffic vs model.
// Latency: checks ex_* one cycle after each applied input set.
// Backpressure: exercises ex_stall, flush and load-use bubbles.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        flush;
    logic        ex_stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_dest;
    logic [5:0]  ex_opcode, ex_funct;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src_imm, ex_illegal;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .id_ready(id_ready),
        .flush(flush), .ex_stall(ex_stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_dest(ex_dest),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_alu_src_imm(ex_alu_src_imm), .ex_illegal(ex_illegal)
    );

    int checks   = 0;
    int failures = 0;

    // Expected execute-side view; ctrl = {reg_write, mem_read, mem_write, branch, alu_src_imm, illegal}.
    typedef struct {
        logic        vld;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  rs_a, rt_a, dest;
        logic [5:0]  op, fn, ctrl;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic        fl, st, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_rdy, e_vld;
        logic [31:0] e_rs, e_rt, e_imm;
        logic [4:0]  e_dest;
        logic [5:0]  e_ctrl;
    } vec_t;

    exp_t        m;
    logic [31:0] mrf [32];
    logic        m_rdy;
    vec_t        tbl [16];

    task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [129:0] dut_vec();
        return {ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs_addr, ex_rt_addr, ex_dest,
                ex_opcode, ex_funct, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
                ex_alu_src_imm, ex_illegal};
    endfunction

    function automatic logic [129:0] model_vec();
        return {m.vld, m.rs_d, m.rt_d, m.imm, m.rs_a, m.rt_a, m.dest, m.op, m.fn, m.ctrl};
    endfunction

    function automatic logic [5:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:               return 6'b100000;
            6'h23:               return 6'b110010;
            6'h2B:               return 6'b001010;
            6'h04:               return 6'b000100;
            6'h08, 6'h0C, 6'h0D: return 6'b100010;
            default:             return 6'b000001;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return mrf[a];
    endfunction

    task automatic model_reset();
        m = '{vld: 1'b0, rs_d: 32'h0, rt_d: 32'h0, imm: 32'h0, rs_a: 5'h0, rt_a: 5'h0,
              dest: 5'h0, op: 6'h0, fn: 6'h0, ctrl: 6'h0};
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    endtask

    // One cycle of the stage as described by its rules: ready, then the next ex view, then RF write.
    task automatic model_step(input logic v, input logic [31:0] ins, input logic fl, input logic st,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic       rtu, haz;
        op  = ins[31:26];
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        rtu = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        haz = m.vld && m.ctrl[4] && (m.dest != 0) && ((m.dest == rs) || (rtu && m.dest == rt));
        m_rdy = fl || (!st && !haz);
        if (fl) begin
            m.vld = 1'b0; m.ctrl = 6'h0;
        end else if (st) begin
            if (we && wa != 0 && wa == m.rs_a) m.rs_d = wd;
            if (we && wa != 0 && wa == m.rt_a) m.rt_d = wd;
        end else if (haz || !v) begin
            m.vld = 1'b0; m.ctrl = 6'h0;
        end else begin
            m.vld  = 1'b1;
            m.rs_d = ref_read(rs, we, wa, wd);
            m.rt_d = ref_read(rt, we, wa, wd);
            m.imm  = (op == 6'h0C || op == 6'h0D) ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
            m.rs_a = rs;
            m.rt_a = rt;
            if (op == 6'h00) m.dest = rd;
            else if (op == 6'h23 || op == 6'h08 || op == 6'h0C || op == 6'h0D) m.dest = rt;
            else m.dest = 5'd0;
            m.op   = op;
            m.fn   = ins[5:0];
            m.ctrl = ref_ctrl(op);
        end
        if (we && wa != 0) mrf[wa] = wd;
    endtask

    // Drive one input set, check id_ready before the edge and the whole ex view after it.
    task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic st,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        output logic rdy_seen);
        if_valid = v; if_instr = ins; flush = fl; ex_stall = st;
        wb_en = we; wb_addr = wa; wb_data = wd;
        model_step(v, ins, fl, st, we, wa, wd);
        #1;
        rdy_seen = id_ready;
        chk("id_ready", {129'h0, id_ready}, {129'h0, m_rdy});
        @(posedge clk);
        #1;
        chk("ex_bundle", dut_vec(), model_vec());
    endtask

    initial begin
        logic        r;
        logic [5:0]  op;
        logic [31:0] ins;

        tbl[0]  = '{0, 32'h00000000, 0, 0, 1, 5'd5, 32'hDEADBEEF, 1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 6'h00};
        tbl[1]  = '{1, 32'h00A01820, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'hDEADBEEF, 32'h0, 32'h1820, 5'd3, 6'h20};
        tbl[2]  = '{1, 32'h20E8FFFF, 0, 0, 1, 5'd7, 32'h1234, 1, 1, 32'h1234, 32'h0, 32'hFFFFFFFF, 5'd8, 6'h22};
        tbl[3]  = '{1, 32'h340A8000, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h00008000, 5'd10, 6'h22};
        tbl[4]  = '{1, 32'h8C220000, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h0, 5'd2, 6'h32};
        tbl[5]  = '{1, 32'h00422020, 0, 0, 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 6'h00};
        tbl[6]  = '{1, 32'h00422020, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h2020, 5'd4, 6'h20};
        tbl[7]  = '{1, 32'h8C220000, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h0, 5'd2, 6'h32};
        tbl[8]  = '{1, 32'h21240001, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h1, 5'd4, 6'h22};
        tbl[9]  = '{1, 32'h00001820, 0, 0, 1, 5'd0, 32'hFFFF, 1, 1, 32'h0, 32'h0, 32'h1820, 5'd3, 6'h20};
        tbl[10] = '{1, 32'hFC000000, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h0, 5'd0, 6'h01};
        tbl[11] = '{1, 32'h00C00820, 0, 0, 0, 5'd0, 32'h0, 1, 1, 32'h0, 32'h0, 32'h0820, 5'd1, 6'h20};
        tbl[12] = '{1, 32'h21240001, 0, 1, 1, 5'd6, 32'hAA, 0, 1, 32'hAA, 32'h0, 32'h0820, 5'd1, 6'h20};
        tbl[13] = '{1, 32'h21240001, 0, 1, 0, 5'd0, 32'h0, 0, 1, 32'hAA, 32'h0, 32'h0820, 5'd1, 6'h20};
        tbl[14] = '{1, 32'h21240001, 0, 1, 0, 5'd0, 32'h0, 0, 1, 32'hAA, 32'h0, 32'h0820, 5'd1, 6'h20};
        tbl[15] = '{1, 32'h21240001, 1, 1, 0, 5'd0, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0, 5'd0, 6'h00};

        rst = 1'b1; if_valid = 0; if_instr = 0; flush = 0; ex_stall = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("reset_state", dut_vec(), 130'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", {129'h0, id_ready}, {129'h0, 1'b1});
        @(posedge clk); #1;

        // Directed vectors from the intended behaviour, cross-checked by the model as well.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].instr, tbl[i].fl, tbl[i].st, tbl[i].we, tbl[i].wa, tbl[i].wd, r);
            chk($sformatf("tbl%0d_ready", i), {129'h0, r}, {129'h0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_valid", i), {129'h0, ex_valid}, {129'h0, tbl[i].e_vld});
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_rs", i), {98'h0, ex_rs_data}, {98'h0, tbl[i].e_rs});
                chk($sformatf("tbl%0d_rt", i), {98'h0, ex_rt_data}, {98'h0, tbl[i].e_rt});
                chk($sformatf("tbl%0d_imm", i), {98'h0, ex_imm}, {98'h0, tbl[i].e_imm});
                chk($sformatf("tbl%0d_dest", i), {125'h0, ex_dest}, {125'h0, tbl[i].e_dest});
                chk($sformatf("tbl%0d_ctrl", i),
                    {124'h0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src_imm, ex_illegal},
                    {124'h0, tbl[i].e_ctrl});
            end
        end

        // Randomized traffic on a narrow register window so hazards and bypasses are frequent.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 8))
                0:       op = 6'h00;
                1:       op = 6'h23;
                2:       op = 6'h2B;
                3:       op = 6'h04;
                4:       op = 6'h08;
                5:       op = 6'h0C;
                6:       op = 6'h0D;
                7:       op = 6'h23;
                default: op = 6'($urandom);
            endcase
            ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            step($urandom_range(0, 9) != 0, ins, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom, r);
        end

        // Asynchronous reset in the middle of a cycle holding a live instruction.
        for (int i = 1; i < 8; i++) begin
            step(0, 32'h0, 0, 0, 1, 5'(i), 32'h1000 + i, r);
        end
        step(1, 32'h00A01820, 0, 0, 0, 5'd0, 32'h0, r);
        chk("pre_rst_valid", {129'h0, ex_valid}, {129'h0, 1'b1});
        #3;
        rst = 1'b1;
        if_valid = 1'b1;
        if_instr = 32'h00A01820;
        #1;
        chk("async_rst_clear", dut_vec(), 130'h0);
        model_reset();
        @(posedge clk); #1;
        chk("rst_edge_no_accept", dut_vec(), 130'h0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 32'h0, 0, 0, 0, 5'd0, 32'h0, r);
        for (int i = 1; i < 32; i++) begin
            step(1, {6'h00, 5'(i), 5'd0, 5'd1, 5'd0, 6'h20}, 0, 0, 0, 5'd0, 32'h0, r);
            chk($sformatf("rf_clear_r%0d", i), {98'h0, ex_rs_data}, 130'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
